// File: rtl/lo_ti_fsk_rx.sv
// lo_ti_fsk_rx: LF FSK receiver. Demodulates cross_lo, locks on 0x7E and streams frame bytes out.
// Define LO_TI_RX_CRC_EN to build the CRC-16 residue check; without it crc_ok is tied low.
module lo_ti_fsk_rx #(
    parameter int unsigned PERIOD_SPLIT = 187,
    parameter int unsigned MIN_PERIOD   = 150,
    parameter int unsigned MAX_PERIOD   = 230,
    parameter int unsigned RUN_BIT      = 16,
    parameter int unsigned FRAME_BYTES  = 10
) (
    input  logic       pck0,
    input  logic       rst,
    input  logic       cross_lo,
    input  logic       ssp_dout,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       frame_start,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       err
);
    localparam int unsigned PW = 8;
    localparam int unsigned RW = 5;
    localparam int unsigned BW = $clog2(FRAME_BYTES + 1);
    localparam logic [7:0] START_BYTE = 8'h7E;

    typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;
    state_t state;

    logic          sync_q1, sync_q2, sync_q3, edge_c;
    logic [PW-1:0] per_cnt;
    logic          have_edge, per_valid, per_cls, per_bad;
    logic [RW-1:0] run_len, run_nx_c;
    logic          cls, cls_nx_c, emit_c, short_c;
    logic [7:0]    shreg, shreg_nx_c;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] byte_cnt;
    logic          bad_c, lock_c, step_c, byte_c, last_c;

    // Comparator synchronizer and rising-edge detect
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= cross_lo;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end
    assign edge_c = sync_q2 & ~sync_q3;

    // Period counter; the first edge after IDLE only arms the measurement
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            per_cnt   <= '0;
            have_edge <= 1'b0;
            per_valid <= 1'b0;
            per_cls   <= 1'b0;
            per_bad   <= 1'b0;
        end else begin
            per_valid <= edge_c & have_edge & (state != IDLE);
            per_cls   <= (per_cnt >= PW'(PERIOD_SPLIT));
            per_bad   <= (per_cnt < PW'(MIN_PERIOD)) || (per_cnt > PW'(MAX_PERIOD));
            if (edge_c) begin
                per_cnt <= PW'(1);
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + PW'(1);
            end
            if (state == IDLE) begin
                have_edge <= 1'b0;
            end else if (edge_c) begin
                have_edge <= 1'b1;
            end
        end
    end

    // Run-length bit recovery; run_len==0 marks a cell boundary just emitted
    always_comb begin
        emit_c   = 1'b0;
        short_c  = 1'b0;
        run_nx_c = run_len;
        cls_nx_c = cls;
        if (per_valid && !per_bad) begin
            if (per_cls == cls) begin
                if (run_len + RW'(1) == RW'(RUN_BIT)) begin
                    emit_c   = 1'b1;
                    run_nx_c = '0;
                end else begin
                    run_nx_c = run_len + RW'(1);
                end
            end else begin
                if (run_len >= RW'(RUN_BIT / 2)) begin
                    emit_c = 1'b1;
                end else if (run_len != '0) begin
                    short_c = 1'b1;
                end
                cls_nx_c = per_cls;
                run_nx_c = RW'(1);
            end
        end
    end

    assign shreg_nx_c = {cls, shreg[7:1]};
    assign bad_c  = per_valid & per_bad;
    assign lock_c = (state == HUNT) & ~ssp_dout & ~bad_c & emit_c & (shreg_nx_c == START_BYTE);
    assign step_c = (state == DATA) & ~ssp_dout & ~bad_c & ~short_c & emit_c;
    assign byte_c = step_c & (bit_cnt == 3'd7);
    assign last_c = byte_c & (byte_cnt + BW'(1) == BW'(FRAME_BYTES));

    // Framing FSM and one-entry output buffer
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            run_len     <= '0;
            cls         <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_start <= lock_c;
            frame_done  <= last_c;
            if (ssp_dout) begin
                state     <= IDLE;
                run_len   <= '0;
                shreg     <= '0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                out_valid <= 1'b0;
                err       <= 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                case (state)
                    IDLE: state <= HUNT;
                    default: begin
                        if (bad_c) begin
                            err     <= 1'b1;
                            run_len <= '0;
                            state   <= HUNT;
                        end else begin
                            run_len <= run_nx_c;
                            cls     <= cls_nx_c;
                            if (emit_c) begin
                                shreg <= shreg_nx_c;
                            end
                            if (state == DATA && short_c) begin
                                err   <= 1'b1;
                                state <= HUNT;
                            end
                            if (lock_c) begin
                                state    <= DATA;
                                bit_cnt  <= '0;
                                byte_cnt <= '0;
                            end
                            if (step_c) begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                            if (byte_c) begin
                                byte_cnt <= byte_cnt + BW'(1);
                                if (out_valid && !out_ready) begin
                                    err <= 1'b1;
                                end else begin
                                    out_data  <= shreg_nx_c;
                                    out_valid <= 1'b1;
                                end
                            end
                            if (last_c) begin
                                state <= HUNT;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef LO_TI_RX_CRC_EN
    logic [15:0] crc_q, crc_nx_c;
    logic        crc_ok_q;

    // Reflected CRC-16 (0x8408), one recovered bit per step
    always_comb begin
        crc_nx_c = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ cls) ? 16'h8408 : 16'h0000);
    end

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            crc_q    <= '0;
            crc_ok_q <= 1'b0;
        end else if (ssp_dout || lock_c) begin
            crc_q    <= '0;
            crc_ok_q <= 1'b0;
        end else if (step_c) begin
            crc_q <= crc_nx_c;
            if (last_c) begin
                crc_ok_q <= (crc_nx_c == 16'h0000);
            end
        end
    end
    assign crc_ok = crc_ok_q;
`else
    assign crc_ok = 1'b0;
`endif

endmodule

// File: doc/lo_ti_fsk_rx.md
# lo_ti_fsk_rx

- FPGA-side receiver for TI low-frequency FSK transponder replies.
- Demodulates the comparator output `cross_lo` while the antenna is in listen mode, which removes the need to stream raw comparator data to the ARM.
- Recovers bits, locks on the 0x7E start byte and delivers frame bytes over a valid/ready byte interface to the SSP serializer.
- Sits in the LF path alongside the antenna-drive logic; `ssp_dout` high (charge phase) holds the receiver idle.

## Interface
Parameters:
- PERIOD_SPLIT, 187: carrier period in `pck0` cycles; a period ≥ this is class 1 (123.2 kHz), otherwise class 0 (134.2 kHz).
- MIN_PERIOD, 150: shortest legal carrier period.
- MAX_PERIOD, 230: longest legal carrier period.
- RUN_BIT, 16: same-class periods per bit cell.
- FRAME_BYTES, 10: bytes delivered after the start byte (8 ID + 2 CRC).

Ports:
- pck0  in  1  24 MHz clock.
- rst  in  1  asynchronous reset, active-high.
- cross_lo  in  1  asynchronous comparator output.
- ssp_dout  in  1  charge enable from ARM; high forces IDLE.
- out_ready  in  1  consumer accepts byte.
- out_data  out  8  received byte.
- out_valid  out  1  out_data valid.
- frame_start  out  1  one-cycle pulse when 0x7E is detected.
- frame_done  out  1  one-cycle pulse after the FRAME_BYTES-th byte is loaded.
- crc_ok  out  1  CRC result, valid with frame_done.
- err  out  1  sticky error flag; cleared by reset or entry to IDLE.

## Operation
- Front end:
  - `cross_lo` passes through a 2-FF synchronizer, then rising-edge detection.
  - An 8-bit period counter saturates at 255 and restarts at 1 on each edge.
  - The first edge after entering HUNT only starts the counter; it is not classified.
- Classification: each completed period is classified against PERIOD_SPLIT. A period < MIN_PERIOD or > MAX_PERIOD is illegal.
- Run-length bit recovery (5-bit run_len, current class cls):
  - Same class as cls: run_len++. When run_len reaches RUN_BIT, emit bit = cls and set run_len = 0.
  - Different class: if run_len ≥ RUN_BIT/2, emit bit = old cls. Then cls = new class and run_len = 1.
  - Different class with run_len < RUN_BIT/2: in DATA this sets err and forces HUNT; in HUNT it is silent.
- Bits are LSB-first and shift into an 8-bit register from the MSB side.
- FSM:
  - IDLE: entered on reset or `ssp_dout`=1. Clears the shift register, run_len, byte count and err. Goes to HUNT on the first cycle with `ssp_dout`=0.
  - HUNT: every emitted bit shifts the window. When the window equals 0x7E, pulse frame_start, clear the bit count and go to DATA.
  - DATA: every 8 bits form one byte. The byte loads into the output buffer and the byte count increments. When count = FRAME_BYTES, pulse frame_done and go to HUNT.
- Any state: an illegal period sets err and forces HUNT; in DATA the frame is abandoned and frame_done is not pulsed.
- Output buffer (one entry):
  - out_valid rises on load and falls on the cycle after out_valid & out_ready.
  - A byte completing while the buffer is still full is dropped and sets err. The held byte stays unchanged.
  - Load and accept in the same cycle: the new byte replaces the old one and out_valid stays high.
- `ssp_dout` rising mid-frame: IDLE on the next edge. out_valid is cleared, no frame_done.

## Timing
- Reset values: out_data=0x00, out_valid=0, frame_start=0, frame_done=0, crc_ok=0, err=0; FSM in IDLE.
- Carrier edge to period classification: 3 cycles (2 sync + 1 edge).
- Last bit's classification to out_valid high: 1 cycle.
- frame_done pulses in the same cycle that out_valid rises for the final byte.
- frame_start pulses 1 cycle after the closing bit of 0x7E is classified.

## Configuration
- LO_TI_RX_CRC_EN defined:
  - A CRC-16, reflected polynomial 0x8408, init 0x0000, is updated LSB-first over every DATA byte, including the 2 CRC bytes.
  - crc_ok = (residue == 0) at frame_done, held until the next frame_start or IDLE.
- Not defined: no CRC logic; crc_ok is tied 0.

## Test plan
- Clean frame: 0x7E, ID 01 02 03 04 05 06 07 08 plus a valid CRC, at periods 179/195, `out_ready`=1 → frame_start once, 10 bytes in order, frame_done with the last byte, crc_ok=1 (CRC_EN), err=0.
- Backpressure: `out_ready`=0 for the whole frame → first byte 0x01 held, err=1 on the second byte, out_valid stays high.
- Illegal period: inject a 120-cycle period after the 3rd byte → err=1, FSM in HUNT, no frame_done.
- Charge interrupt: `ssp_dout`=1 for 100 cycles mid-frame → out_valid=0, err=0, FSM in IDLE; the next clean frame is received correctly.
- Short cell: a class-1 run of 5 periods inside DATA → err=1 and HUNT. The same run during HUNT → no err.
- CRC corruption: flip one ID bit → frame_done pulses with crc_ok=0 (CRC_EN) or crc_ok=0 (no CRC_EN).
